// File: rtl/pack_rq0_stream.sv
// pack_rq0_stream: packs N_COEF Q_BITS-bit coefficients into a little-endian byte stream.
// Coefficients are appended above the valid fill bits; bytes leave from the bottom.
module pack_rq0_stream #(
  parameter int N_COEF = 700,
  parameter int Q_BITS = 13,
  parameter int IN_W   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] coef_in,
  input  logic            coef_valid,
  output logic            coef_ready,
  output logic [7:0]      byte_out,
  output logic            byte_valid,
  input  logic            byte_ready,
  output logic            busy,
  output logic            done
);
  localparam int OUT_BYTES = (N_COEF * Q_BITS + 7) / 8;
  localparam int ACC_W     = Q_BITS + 8;
  localparam int FW        = $clog2(ACC_W + 1);
  localparam int CW        = $clog2(N_COEF + 1);
  localparam int BW        = $clog2(OUT_BYTES + 1);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sh;
  logic [FW-1:0]    fill_q, fill_d, fill_rem, dec;
  logic [CW-1:0]    coef_cnt_q, coef_cnt_d;
  logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
  logic             coef_x, byte_x, last, go, unused_hi;
  always_comb begin
    unused_hi  = ^coef_in[IN_W-1:Q_BITS];
    coef_ready = state_q == RUN && fill_q < FW'(8) && coef_cnt_q < CW'(N_COEF);
    byte_valid = fill_q >= FW'(8) || (state_q == FLUSH && fill_q != '0);
    byte_out   = acc_q[7:0];
    busy       = state_q == RUN || state_q == FLUSH;
    done       = state_q == DONE;
    coef_x     = coef_valid && coef_ready;
    byte_x     = byte_valid && byte_ready;
    last       = byte_x && byte_cnt_q == BW'(OUT_BYTES - 1);
    go         = state_q == IDLE && start;
    dec        = fill_q >= FW'(8) ? FW'(8) : fill_q;
    fill_rem   = byte_x ? fill_q - dec : fill_q;
    acc_sh     = byte_x ? acc_q >> 8 : acc_q;
    // new bits land just above whatever survives this cycle's byte shift
    acc_d      = go ? '0 : coef_x ? acc_sh | (ACC_W'(coef_in[Q_BITS-1:0]) << fill_rem) : acc_sh;
    fill_d     = go ? '0 : coef_x ? fill_rem + FW'(Q_BITS) : fill_rem;
    coef_cnt_d = go ? '0 : coef_cnt_q + CW'(coef_x);
    byte_cnt_d = go ? '0 : byte_cnt_q + BW'(byte_x);
    state_d    = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = last ? DONE : coef_cnt_q == CW'(N_COEF) ? FLUSH : RUN;
      FLUSH:   state_d = last ? DONE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      fill_q     <= '0;
      coef_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      coef_cnt_q <= coef_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end
endmodule

// File: tb/tb_pack_rq0_stream.sv
// tb_pack_rq0_stream: scoreboard bench for pack_rq0_stream against a bit-level pack model.
module tb_pack_rq0_stream;
  localparam int N  = 700;
  localparam int Q  = 13;
  localparam int W  = 16;
  localparam int OB = (N * Q + 7) / 8;
  logic         clk = 0, rst_n = 0, start = 0, coef_valid = 0, byte_ready = 0;
  logic [W-1:0] coef_in = '0;
  logic         coef_ready, byte_valid, busy, done;
  logic [7:0]   byte_out;
  int           passed = 0, total = 0;
  logic [W-1:0] cin [N];
  logic [7:0]   exp_q [$];
  logic [7:0]   got [$];

  pack_rq0_stream dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coef_in(coef_in), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push_expected();
    exp_q.delete();
    for (int b = 0; b < OB; b++) begin
      logic [7:0] v;
      v = '0;
      for (int j = 0; j < 8; j++) begin
        int k;
        k = b * 8 + j;
        if (k < N * Q) v[j] = cin[k / Q][k % Q];
      end
      exp_q.push_back(v);
    end
  endtask

  task automatic run_frame(input int pc, input int pb, input int mid_start, input int abort_at,
                           output int nb, output int nd, output int mism, output int stall_err,
                           output int busy_err, output int tmo);
    int idx, cyc;
    bit hold, fin;
    logic [7:0] held;
    idx = 0; cyc = 0; hold = 0; fin = 0; held = '0;
    nb = 0; nd = 0; mism = 0; stall_err = 0; busy_err = 0; tmo = 0;
    got.delete();
    @(posedge clk); #1;
    start = 1; coef_valid = 0; byte_ready = 0;
    @(posedge clk); #1;
    start = 0;
    while (!fin) begin
      coef_valid = $urandom_range(99) >= pc;
      coef_in    = (coef_valid && idx < N) ? cin[idx] : W'($urandom);
      byte_ready = $urandom_range(99) >= pb;
      start      = mid_start >= 0 && idx >= mid_start && idx < mid_start + 3;
      @(negedge clk);
      if (hold && (!byte_valid || byte_out !== held)) stall_err++;
      hold = byte_valid && !byte_ready;
      held = byte_out;
      if (done) begin
        nd++;
        fin = 1;
      end else if (busy !== 1'b1) busy_err++;
      if (coef_valid && coef_ready) idx++;
      if (byte_valid && byte_ready) begin
        nb++;
        got.push_back(byte_out);
        if (exp_q.size() == 0) mism++;
        else if (exp_q.pop_front() !== byte_out) mism++;
      end
      cyc++;
      if (cyc > 20000) begin
        tmo = 1;
        fin = 1;
      end
      if (abort_at >= 0 && nb == abort_at) fin = 1;
      @(posedge clk); #1;
    end
    start = 0; coef_valid = 0; byte_ready = 1;
    if (abort_at < 0 && !tmo)
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (done) nd++;
        if (busy) busy_err++;
      end
    byte_ready = 0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (coef_ready !== 1'b0) $display("FAIL reset_coef_ready: got %b want 0", coef_ready); else passed++;
    total++; if (byte_valid !== 1'b0) $display("FAIL reset_byte_valid: got %b want 0", byte_valid); else passed++;
    total++; if (byte_out !== 8'h00) $display("FAIL reset_byte_out: got %h want 00", byte_out); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
    total++; if (coef_ready !== 1'b0) $display("FAIL idle_coef_ready: got %b want 0", coef_ready); else passed++;
  endtask

  task automatic test_zeros();
    int nb, nd, mism, se, be, tmo;
    for (int i = 0; i < N; i++) cin[i] = '0;
    push_expected();
    run_frame(0, 0, -1, -1, nb, nd, mism, se, be, tmo);
    total++; if (tmo !== 0) $display("FAIL zeros_timeout: got %0d want 0", tmo); else passed++;
    total++; if (nb !== OB) $display("FAIL zeros_count: got %0d want %0d", nb, OB); else passed++;
    total++; if (mism !== 0) $display("FAIL zeros_data: got %0d mismatches want 0", mism); else passed++;
    total++; if (nd !== 1) $display("FAIL zeros_done: got %0d pulses want 1", nd); else passed++;
    total++; if (be !== 0) $display("FAIL zeros_busy: got %0d bad cycles want 0", be); else passed++;
    total++; if (byte_valid !== 1'b0) $display("FAIL zeros_idle_valid: got %b want 0", byte_valid); else passed++;
  endtask

  task automatic test_ones();
    int nb, nd, mism, se, be, tmo;
    logic [7:0] first, lastb;
    for (int i = 0; i < N; i++) cin[i] = 16'h1FFF;
    push_expected();
    run_frame(0, 0, -1, -1, nb, nd, mism, se, be, tmo);
    first = got.size() > 0 ? got[0] : 8'hxx;
    lastb = got.size() == OB ? got[OB-1] : 8'hxx;
    total++; if (nb !== OB) $display("FAIL ones_count: got %0d want %0d", nb, OB); else passed++;
    total++; if (mism !== 0) $display("FAIL ones_data: got %0d mismatches want 0", mism); else passed++;
    total++; if (first !== 8'hFF) $display("FAIL ones_byte0: got %h want ff", first); else passed++;
    total++; if (lastb !== 8'h0F) $display("FAIL ones_last_byte: got %h want 0f", lastb); else passed++;
    total++; if (nd !== 1) $display("FAIL ones_done: got %0d pulses want 1", nd); else passed++;
  endtask

  task automatic test_sparse();
    int nb, nd, mism, se, be, tmo;
    logic [7:0] b0, b1, b3;
    for (int i = 0; i < N; i++) cin[i] = '0;
    cin[0] = 16'h0001; cin[1] = 16'h0002; cin[2] = 16'hE001;
    push_expected();
    run_frame(0, 0, -1, -1, nb, nd, mism, se, be, tmo);
    b0 = got.size() > 3 ? got[0] : 8'hxx;
    b1 = got.size() > 3 ? got[1] : 8'hxx;
    b3 = got.size() > 3 ? got[3] : 8'hxx;
    total++; if (b0 !== 8'h01) $display("FAIL sparse_byte0: got %h want 01", b0); else passed++;
    total++; if (b1 !== 8'h40) $display("FAIL sparse_byte1: got %h want 40", b1); else passed++;
    total++; if (b3 !== 8'h04) $display("FAIL sparse_byte3: got %h want 04", b3); else passed++;
    total++; if (mism !== 0) $display("FAIL sparse_data: got %0d mismatches want 0", mism); else passed++;
    total++; if (nb !== OB) $display("FAIL sparse_count: got %0d want %0d", nb, OB); else passed++;
  endtask

  task automatic test_random_stalls();
    int nb, nd, mism, se, be, tmo;
    for (int i = 0; i < N; i++) cin[i] = W'($urandom);
    push_expected();
    run_frame(30, 35, -1, -1, nb, nd, mism, se, be, tmo);
    total++; if (tmo !== 0) $display("FAIL rand_timeout: got %0d want 0", tmo); else passed++;
    total++; if (nb !== OB) $display("FAIL rand_count: got %0d want %0d", nb, OB); else passed++;
    total++; if (mism !== 0) $display("FAIL rand_data: got %0d mismatches want 0", mism); else passed++;
    total++; if (se !== 0) $display("FAIL rand_stall_stable: got %0d violations want 0", se); else passed++;
    total++; if (nd !== 1) $display("FAIL rand_done: got %0d pulses want 1", nd); else passed++;
    total++; if (be !== 0) $display("FAIL rand_busy: got %0d bad cycles want 0", be); else passed++;
  endtask

  task automatic test_abort();
    int nb, nd, mism, se, be, tmo;
    for (int i = 0; i < N; i++) cin[i] = W'($urandom);
    push_expected();
    run_frame(10, 10, -1, 300, nb, nd, mism, se, be, tmo);
    total++; if (mism !== 0) $display("FAIL abort_partial_data: got %0d mismatches want 0", mism); else passed++;
    #2 rst_n = 0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_rst_busy: got %b want 0", busy); else passed++;
    total++; if (byte_valid !== 1'b0) $display("FAIL abort_rst_valid: got %b want 0", byte_valid); else passed++;
    total++; if (byte_out !== 8'h00) $display("FAIL abort_rst_byte: got %h want 00", byte_out); else passed++;
    @(negedge clk); rst_n = 1;
    byte_ready = 1;
    repeat (3) @(negedge clk);
    total++; if (byte_valid !== 1'b0) $display("FAIL abort_leftover: got %b want 0", byte_valid); else passed++;
    byte_ready = 0;
    for (int i = 0; i < N; i++) cin[i] = W'($urandom);
    push_expected();
    run_frame(20, 20, -1, -1, nb, nd, mism, se, be, tmo);
    total++; if (nb !== OB) $display("FAIL abort_next_count: got %0d want %0d", nb, OB); else passed++;
    total++; if (mism !== 0) $display("FAIL abort_next_data: got %0d mismatches want 0", mism); else passed++;
    total++; if (nd !== 1) $display("FAIL abort_next_done: got %0d pulses want 1", nd); else passed++;
    total++; if (be !== 0) $display("FAIL abort_next_busy: got %0d bad cycles want 0", be); else passed++;
  endtask

  task automatic test_start_mid();
    int nb, nd, mism, se, be, tmo;
    for (int i = 0; i < N; i++) cin[i] = W'($urandom);
    push_expected();
    run_frame(5, 5, 350, -1, nb, nd, mism, se, be, tmo);
    total++; if (nb !== OB) $display("FAIL midstart_count: got %0d want %0d", nb, OB); else passed++;
    total++; if (mism !== 0) $display("FAIL midstart_data: got %0d mismatches want 0", mism); else passed++;
    total++; if (nd !== 1) $display("FAIL midstart_done: got %0d pulses want 1", nd); else passed++;
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones();
    test_sparse();
    test_random_stalls();
    test_abort();
    test_start_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
